// File: rtl/uart_rx_word.sv
`default_nettype none
// ============================================================================
//  Module   : uart_rx_word
//  Purpose  : 8N1 UART receiver that packs four consecutive bytes into one
//             little-endian 32-bit word and emits a one-cycle write strobe
//             per completed word (drives a ring buffer's write port).
//  Ports    : clock        - system clock
//             reset        - synchronous, active-high reset
//             rxd          - asynchronous serial input, idle high
//             we           - one-cycle strobe, wd holds a complete word
//             wd           - assembled word, first byte in [7:0]
//             frame_error  - one-cycle pulse, stop bit sampled low
//             byte_count   - bytes of the current partial word received
//  Revision : 1.0 - initial release
// ============================================================================
module uart_rx_word #(
  // Clock cycles per UART bit; must be at least 4.
  parameter logic [31:0] CLK_PER_BIT = 32'd868
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        rxd,
  output logic        we,
  output logic [31:0] wd,
  output logic        frame_error,
  output logic [1:0]  byte_count
);

  localparam logic [31:0] C_START_LIMIT = (CLK_PER_BIT / 32'd2) - 32'd1;
  localparam logic [31:0] C_BIT_LIMIT   = CLK_PER_BIT - 32'd1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3,
    S_BREAK = 3'd4
  } state_t;

  state_t      state_q,       state_d;
  logic        rx_meta_q,     rx_meta_d;
  logic        rxs_q,         rxs_d;
  logic [31:0] cnt_q,         cnt_d;
  logic [2:0]  bit_idx_q,     bit_idx_d;
  logic [7:0]  shift_q,       shift_d;
  // Holds bytes 0..2 of the word in progress so wd only ever changes as a
  // complete word.
  logic [23:0] acc_q,         acc_d;
  logic [1:0]  byte_count_q,  byte_count_d;
  logic [31:0] wd_q,          wd_d;
  logic        we_q,          we_d;
  logic        frame_error_q, frame_error_d;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= S_IDLE;
      rx_meta_q     <= 1'b1;
      rxs_q         <= 1'b1;
      cnt_q         <= 32'd0;
      bit_idx_q     <= 3'd0;
      shift_q       <= 8'd0;
      acc_q         <= 24'd0;
      byte_count_q  <= 2'd0;
      wd_q          <= 32'd0;
      we_q          <= 1'b0;
      frame_error_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      rx_meta_q     <= rx_meta_d;
      rxs_q         <= rxs_d;
      cnt_q         <= cnt_d;
      bit_idx_q     <= bit_idx_d;
      shift_q       <= shift_d;
      acc_q         <= acc_d;
      byte_count_q  <= byte_count_d;
      wd_q          <= wd_d;
      we_q          <= we_d;
      frame_error_q <= frame_error_d;
    end
  end

  always_comb begin
    // Two-flop synchroniser; only rxs_q feeds decisions below.
    rx_meta_d     = rxd;
    rxs_d         = rx_meta_q;
    state_d       = state_q;
    cnt_d         = cnt_q + 32'd1;
    bit_idx_d     = bit_idx_q;
    shift_d       = shift_q;
    acc_d         = acc_q;
    byte_count_d  = byte_count_q;
    wd_d          = wd_q;
    we_d          = 1'b0;
    frame_error_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (!rxs_q) begin
          state_d = S_START;
          cnt_d   = 32'd0;
        end
      end

      // Re-check the line at mid start bit to reject short glitches.
      S_START: begin
        if (cnt_q == C_START_LIMIT) begin
          cnt_d = 32'd0;
          if (!rxs_q) begin
            state_d   = S_DATA;
            bit_idx_d = 3'd0;
          end else begin
            state_d = S_IDLE;
          end
        end
      end

      // Each limit is the middle of a data bit; LSB arrives first.
      S_DATA: begin
        if (cnt_q == C_BIT_LIMIT) begin
          cnt_d   = 32'd0;
          shift_d = {rxs_q, shift_q[7:1]};
          if (bit_idx_q == 3'd7) begin
            state_d = S_STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end
      end

      S_STOP: begin
        if (cnt_q == C_BIT_LIMIT) begin
          cnt_d = 32'd0;
          if (rxs_q) begin
            state_d = S_IDLE;
            case (byte_count_q)
              2'd0: acc_d[7:0]   = shift_q;
              2'd1: acc_d[15:8]  = shift_q;
              2'd2: acc_d[23:16] = shift_q;
              default: begin
                wd_d = {shift_q, acc_q};
                we_d = 1'b1;
              end
            endcase
            byte_count_d = byte_count_q + 2'd1;
          end else begin
            // Bad stop bit: drop this byte and the partial word, then wait
            // for the line to return high so a held-low line flags once.
            state_d       = S_BREAK;
            frame_error_d = 1'b1;
            byte_count_d  = 2'd0;
          end
        end
      end

      S_BREAK: begin
        if (rxs_q) begin
          state_d = S_IDLE;
          cnt_d   = 32'd0;
        end
      end

      default: begin
        state_d = S_IDLE;
        cnt_d   = 32'd0;
      end
    endcase
  end

  assign we          = we_q;
  assign wd          = wd_q;
  assign frame_error = frame_error_q;
  assign byte_count  = byte_count_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_word.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_rx_word
//  Purpose  : Self-checking bench for uart_rx_word with CLK_PER_BIT = 8.
//             Expected words and frame errors are queued when stimulus is
//             driven and consumed when the DUT raises we / frame_error.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx_word;

  localparam int CPB = 8;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        rxd   = 1'b1;
  logic        we;
  logic [31:0] wd;
  logic        frame_error;
  logic [1:0]  byte_count;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_wd_q[$];
  bit          exp_fe_q[$];
  logic [31:0] wd_hold = 32'd0;
  logic [31:0] exp_tmp;

  uart_rx_word #(.CLK_PER_BIT(32'd8)) dut (
    .clock       (clock),
    .reset       (reset),
    .rxd         (rxd),
    .we          (we),
    .wd          (wd),
    .frame_error (frame_error),
    .byte_count  (byte_count)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Output monitor: sampled on the falling edge, away from the active edge.
  always @(negedge clock) begin
    if (we === 1'b1) begin
      check("we_expected", 32'(exp_wd_q.size() != 0), 32'd1);
      if (exp_wd_q.size() != 0) begin
        exp_tmp = exp_wd_q.pop_front();
        check("wd", wd, exp_tmp);
        wd_hold = exp_tmp;
      end
    end else begin
      check("wd_stable", wd, wd_hold);
    end
    if (frame_error === 1'b1) begin
      check("frame_error_expected", 32'(exp_fe_q.size() != 0), 32'd1);
      if (exp_fe_q.size() != 0) void'(exp_fe_q.pop_front());
    end
  end

  task automatic send_bit(input logic v);
    rxd = v;
    repeat (CPB) @(posedge clock);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(stop);
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) begin
      if (i == 3) exp_wd_q.push_back(w);
      send_byte(w[8*i +: 8], 1'b1);
      check("byte_count", {30'd0, byte_count}, 32'((i + 1) % 4));
    end
  endtask

  task automatic idle(input int n);
    rxd = 1'b1;
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic check_drained(input string tag);
    check({tag, "_pending_we"}, 32'(exp_wd_q.size()), 32'd0);
    check({tag, "_pending_fe"}, 32'(exp_fe_q.size()), 32'd0);
  endtask

  initial begin
    // Reset state
    repeat (4) @(posedge clock);
    #1;
    check("rst_we", {31'd0, we}, 32'd0);
    check("rst_wd", wd, 32'd0);
    check("rst_fe", {31'd0, frame_error}, 32'd0);
    check("rst_bc", {30'd0, byte_count}, 32'd0);
    reset = 1'b0;
    idle(4);

    // Basic word
    send_word(32'h12345678);
    idle(16);
    check_drained("t1");

    // Short glitch shorter than half a bit
    rxd = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    idle(40);
    check("glitch_bc", {30'd0, byte_count}, 32'd0);
    check_drained("t2");

    // Framing error drops the partial word
    send_byte(8'h11, 1'b1);
    check("fe_pre_bc", {30'd0, byte_count}, 32'd1);
    exp_fe_q.push_back(1'b1);
    send_byte(8'h5A, 1'b0);
    check("fe_post_bc", {30'd0, byte_count}, 32'd0);
    idle(CPB);
    send_word(32'hDDCCBBAA);
    idle(16);
    check_drained("t3");

    // Reset during bit 3 of the second byte
    send_byte(8'hA5, 1'b1);
    send_bit(1'b0);
    send_bit(1'b0);
    send_bit(1'b0);
    send_bit(1'b1);
    rxd = 1'b1;
    repeat (4) @(posedge clock);
    #1;
    reset = 1'b1;
    @(posedge clock);
    #1;
    wd_hold = 32'd0;
    repeat (2) @(posedge clock);
    #1;
    check("mid_rst_we", {31'd0, we}, 32'd0);
    check("mid_rst_wd", wd, 32'd0);
    check("mid_rst_fe", {31'd0, frame_error}, 32'd0);
    check("mid_rst_bc", {30'd0, byte_count}, 32'd0);
    reset = 1'b0;
    idle(CPB);
    send_word(32'h04030201);
    idle(16);
    check_drained("t4");

    // Eight bytes back-to-back, no idle gap
    send_word(32'h03020100);
    send_word(32'h07060504);
    idle(16);
    check_drained("t5");

    // Line held low: one frame error, no restart until high again
    exp_fe_q.push_back(1'b1);
    rxd = 1'b0;
    repeat (120) @(posedge clock);
    #1;
    check("break_bc", {30'd0, byte_count}, 32'd0);
    check("break_fe_seen", 32'(exp_fe_q.size()), 32'd0);
    idle(2 * CPB);
    send_word(32'hDEADBEEF);
    idle(16);
    check_drained("t6");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
